// File: rtl/ahb_lite_to_tl_ul_bridge.sv
// AHB-Lite slave to TileLink-UL master bridge: one TL Get/Put per AHB transfer, data phase stalled until D returns.
// Optional posted writes are enabled by defining AHB2TL_POSTED_WRITE_EN.
module ahb_lite_to_tl_ul_bridge #(
  parameter int unsigned          SRC_W  = 1,
  parameter logic [SRC_W-1:0]     SRC_ID = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_hsel,
  input  logic [1:0]        i_htrans,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [2:0]        i_hburst,
  input  logic [31:0]       i_haddr,
  input  logic [31:0]       i_hwdata,
  input  logic              i_hready_in,
  output logic              o_hreadyout,
  output logic              o_hresp,
  output logic [31:0]       o_hrdata,
  output logic              o_a_valid,
  input  logic              i_a_ready,
  output logic [2:0]        o_a_opcode,
  output logic [2:0]        o_a_param,
  output logic [2:0]        o_a_size,
  output logic [SRC_W-1:0]  o_a_source,
  output logic [31:0]       o_a_address,
  output logic [3:0]        o_a_mask,
  output logic [31:0]       o_a_data,
  input  logic              i_d_valid,
  output logic              o_d_ready,
  input  logic [2:0]        i_d_opcode,
  input  logic              i_d_denied,
  input  logic              i_d_corrupt,
  input  logic [31:0]       i_d_data
);

  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] D_ACK        = 3'd0;
  localparam logic [2:0] D_ACK_DATA   = 3'd1;

`ifdef AHB2TL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_ERR1 = 3'd4,
    S_ERR2 = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_posted;
  logic         w_posted_nxt;
  logic         w_hrdata_load;

  logic         r_hreadyout;
  logic         r_hresp;
  logic [31:0]  r_hrdata;
  logic         r_a_valid;
  logic         r_d_ready;
  logic         w_hreadyout_nxt;
  logic         w_hresp_nxt;
  logic         w_a_valid_nxt;
  logic         w_d_ready_nxt;

  logic         r_wr;
  logic [2:0]   r_a_opcode;
  logic [2:0]   r_a_size;
  logic [31:0]  r_a_address;
  logic [3:0]   r_a_mask;

  logic         w_accept;
  logic         w_can_sample;
  logic         w_capture;
  logic         w_bad;
  logic [3:0]   w_mask;
  logic         w_a_fire;
  logic         w_d_fire;
  logic         w_d_err;
  logic         w_unused;

  assign w_unused = ^{i_hburst, i_htrans[0]};

  // Address phase is only sampled while the previous data phase is completing
  assign w_accept     = i_hsel & i_htrans[1] & i_hready_in;
  assign w_can_sample = (r_state == S_IDLE) | (r_state == S_RESP) | (r_state == S_ERR2);
  assign w_capture    = w_accept & w_can_sample;
  assign w_bad        = (i_hsize > 3'd2)
                      | ((i_hsize == 3'd1) & i_haddr[0])
                      | ((i_hsize == 3'd2) & (i_haddr[1:0] != 2'b00));

  assign w_a_fire = r_a_valid & i_a_ready;
  assign w_d_fire = r_d_ready & i_d_valid;
  assign w_d_err  = i_d_denied | i_d_corrupt | (i_d_opcode != (r_wr ? D_ACK : D_ACK_DATA));

  always_comb begin
    w_mask = 4'hF;
    case (i_hsize[1:0])
      2'd0:    w_mask = 4'b0001 << i_haddr[1:0];
      2'd1:    w_mask = 4'b0011 << {i_haddr[1], 1'b0};
      default: w_mask = 4'hF;
    endcase
  end

  // Next-state logic; output values are decoded from the next state and registered
  always_comb begin
    w_state_nxt   = r_state;
    w_posted_nxt  = r_posted;
    w_hrdata_load = 1'b0;

    case (r_state)
      S_IDLE, S_RESP, S_ERR2: begin
        if (w_capture) begin
          w_state_nxt = w_bad ? S_ERR1 : S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_a_fire) begin
          w_state_nxt = (POSTED && r_wr) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_d_fire) begin
          if (w_d_err) begin
            w_state_nxt = S_ERR1;
          end else begin
            w_state_nxt   = S_RESP;
            w_hrdata_load = ~r_wr;
          end
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase

    // A posted write's D beat is sunk whatever state the FSM is in
    if (POSTED) begin
      if (r_posted && w_d_fire) begin
        w_posted_nxt = 1'b0;
      end
      if ((r_state == S_REQ) && w_a_fire && r_wr) begin
        w_posted_nxt = 1'b1;
      end
    end

    w_hreadyout_nxt = ~((w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_ERR1));
    w_hresp_nxt     = (w_state_nxt == S_ERR1) || (w_state_nxt == S_ERR2);
    w_a_valid_nxt   = (w_state_nxt == S_REQ) && !w_posted_nxt;
    w_d_ready_nxt   = (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT) || w_posted_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_posted    <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= 32'd0;
      r_a_valid   <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_posted    <= w_posted_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
      r_a_valid   <= w_a_valid_nxt;
      r_d_ready   <= w_d_ready_nxt;
      if (w_hrdata_load) begin
        r_hrdata <= i_d_data;
      end
    end
  end

  // A-channel fields only change when no request is pending
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr        <= 1'b0;
      r_a_opcode  <= OP_GET;
      r_a_size    <= 3'd0;
      r_a_address <= 32'd0;
      r_a_mask    <= 4'd0;
    end else if (w_capture) begin
      r_wr        <= i_hwrite;
      r_a_opcode  <= i_hwrite ? OP_PUT_FULL : OP_GET;
      r_a_size    <= i_hsize;
      r_a_address <= i_haddr;
      r_a_mask    <= w_mask;
    end
  end

  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;
  assign o_hrdata    = r_hrdata;
  assign o_a_valid   = r_a_valid;
  assign o_a_opcode  = r_a_opcode;
  assign o_a_param   = 3'd0;
  assign o_a_size    = r_a_size;
  assign o_a_source  = SRC_ID;
  assign o_a_address = r_a_address;
  assign o_a_mask    = r_a_mask;
  assign o_a_data    = i_hwdata;
  assign o_d_ready   = r_d_ready;

endmodule

// File: tb/tb_ahb_lite_to_tl_ul_bridge.sv
// Directed bench for ahb_lite_to_tl_ul_bridge; expected A requests are queued at stimulus time and checked on fire.
module tb_ahb_lite_to_tl_ul_bridge;

  logic        clk;
  logic        rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [0:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;

  ahb_lite_to_tl_ul_bridge dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_hsel      (hsel),
    .i_htrans    (htrans),
    .i_hwrite    (hwrite),
    .i_hsize     (hsize),
    .i_hburst    (hburst),
    .i_haddr     (haddr),
    .i_hwdata    (hwdata),
    .i_hready_in (hreadyout),
    .o_hreadyout (hreadyout),
    .o_hresp     (hresp),
    .o_hrdata    (hrdata),
    .o_a_valid   (a_valid),
    .i_a_ready   (a_ready),
    .o_a_opcode  (a_opcode),
    .o_a_param   (a_param),
    .o_a_size    (a_size),
    .o_a_source  (a_source),
    .o_a_address (a_address),
    .o_a_mask    (a_mask),
    .o_a_data    (a_data),
    .i_d_valid   (d_valid),
    .o_d_ready   (d_ready),
    .i_d_opcode  (d_opcode),
    .i_d_denied  (d_denied),
    .i_d_corrupt (d_corrupt),
    .i_d_data    (d_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        wr;
  } a_exp_t;

  a_exp_t      exp_a[$];
  int          n_checks;
  int          n_errors;
  logic [31:0] m_hrdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every A handshake, then advance one cycle
  task automatic step();
    a_exp_t e;
    #1;
    if (a_valid && a_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected", 32'(a_valid), 0);
      end else begin
        e = exp_a.pop_front();
        chk("a_opcode",  32'(a_opcode),  32'(e.op));
        chk("a_size",    32'(a_size),    32'(e.size));
        chk("a_address", a_address,      e.addr);
        chk("a_mask",    32'(a_mask),    32'(e.mask));
        chk("a_param",   32'(a_param),   0);
        chk("a_source",  32'(a_source),  0);
        if (e.wr) chk("a_data", a_data, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata);
    a_exp_t e;
    e.op   = wr ? 3'd0 : 3'd4;
    e.size = sz;
    e.addr = addr;
    e.mask = mask;
    e.data = wdata;
    e.wr   = wr;
    exp_a.push_back(e);
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] addr);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = addr;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wdata, input logic [2:0] dop, input logic den, input logic cor,
                      input logic [31:0] rdata, input int dly, input logic exp_err);
    push_a(wr, sz, addr, mask, wdata);
    addr_phase(wr, sz, addr);
    step();
    bus_idle();
    hwdata  = wdata;
    a_ready = 1'b1;
    chk("req_hreadyout", 32'(hreadyout), 0);
    chk("req_a_valid", 32'(a_valid), 1);
    step();
    a_ready = 1'b0;
`ifdef AHB2TL_POSTED_WRITE_EN
    if (wr) begin
      chk("post_hreadyout", 32'(hreadyout), 1);
      chk("post_hresp", 32'(hresp), 0);
      chk("post_d_ready", 32'(d_ready), 1);
      d_valid = 1'b1; d_opcode = dop; d_denied = den; d_corrupt = cor;
      step();
      d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
      chk("post_idle_hresp", 32'(hresp), 0);
      return;
    end
`endif
    for (int i = 0; i < dly; i++) begin
      chk("wait_hreadyout", 32'(hreadyout), 0);
      chk("wait_d_ready", 32'(d_ready), 1);
      step();
    end
    d_valid = 1'b1; d_opcode = dop; d_denied = den; d_corrupt = cor; d_data = rdata;
    chk("wait_hreadyout", 32'(hreadyout), 0);
    step();
    d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
    if (exp_err) begin
      chk("err1_hreadyout", 32'(hreadyout), 0);
      chk("err1_hresp", 32'(hresp), 1);
      step();
      chk("err2_hreadyout", 32'(hreadyout), 1);
      chk("err2_hresp", 32'(hresp), 1);
      chk("err2_hrdata", hrdata, m_hrdata);
      step();
      chk("err_idle_hresp", 32'(hresp), 0);
      chk("err_idle_a_valid", 32'(a_valid), 0);
    end else begin
      if (!wr) m_hrdata = rdata;
      chk("resp_hreadyout", 32'(hreadyout), 1);
      chk("resp_hresp", 32'(hresp), 0);
      chk("resp_hrdata", hrdata, m_hrdata);
      step();
    end
  endtask

  task automatic bad_addr(input logic [2:0] sz, input logic [31:0] addr);
    addr_phase(1'b0, sz, addr);
    step();
    bus_idle();
    chk("bad_err1_hreadyout", 32'(hreadyout), 0);
    chk("bad_err1_hresp", 32'(hresp), 1);
    chk("bad_err1_a_valid", 32'(a_valid), 0);
    step();
    chk("bad_err2_hreadyout", 32'(hreadyout), 1);
    chk("bad_err2_hresp", 32'(hresp), 1);
    step();
    chk("bad_idle_hresp", 32'(hresp), 0);
    chk("bad_idle_a_valid", 32'(a_valid), 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_hrdata = 32'd0;
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
    haddr = 32'd0; hwdata = 32'd0; a_ready = 1'b0; d_valid = 1'b0; d_opcode = 3'd0;
    d_denied = 1'b0; d_corrupt = 1'b0; d_data = 32'd0;
    step();
    step();
    chk("rst_hreadyout", 32'(hreadyout), 1);
    chk("rst_hresp", 32'(hresp), 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    rst = 1'b0;
    step();
    chk("idle_d_ready", 32'(d_ready), 1);

    // IDLE and BUSY transfers complete with zero wait and no TL traffic
    hsel = 1'b1; htrans = 2'b00; hburst = 3'd3;
    step();
    chk("htrans_idle_hreadyout", 32'(hreadyout), 1);
    chk("htrans_idle_a_valid", 32'(a_valid), 0);
    htrans = 2'b01;
    step();
    chk("htrans_busy_hreadyout", 32'(hreadyout), 1);
    chk("htrans_busy_hresp", 32'(hresp), 0);
    bus_idle();

    xfer(1'b0, 3'd2, 32'h8000_0004, 4'hF, 32'd0, 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    xfer(1'b1, 3'd0, 32'h8000_0003, 4'b1000, 32'hAB00_0000, 3'd0, 1'b0, 1'b0, 32'd0, 2, 1'b0);
    xfer(1'b0, 3'd2, 32'h0000_0010, 4'hF, 32'd0, 3'd1, 1'b1, 1'b0, 32'h1111_1111, 0, 1'b1);
    xfer(1'b0, 3'd0, 32'h0000_0011, 4'b0010, 32'd0, 3'd1, 1'b0, 1'b1, 32'h2222_2222, 1, 1'b1);
    xfer(1'b0, 3'd2, 32'h0000_0014, 4'hF, 32'd0, 3'd0, 1'b0, 1'b0, 32'h3333_3333, 0, 1'b1);
    xfer(1'b1, 3'd1, 32'h0000_0018, 4'b0011, 32'h0000_5A5A, 3'd0, 1'b1, 1'b0, 32'd0, 0, 1'b1);
    xfer(1'b0, 3'd1, 32'h0000_001A, 4'b1100, 32'd0, 3'd1, 1'b0, 1'b0, 32'h4444_4444, 0, 1'b0);

    bad_addr(3'd1, 32'h0000_0001);
    bad_addr(3'd3, 32'h0000_0000);
    bad_addr(3'd2, 32'h0000_0002);

`ifndef AHB2TL_POSTED_WRITE_EN
    // Pipelined write then read with a_ready stalled
    push_a(1'b1, 3'd2, 32'h0000_0020, 4'hF, 32'h1234_5678);
    push_a(1'b0, 3'd1, 32'h0000_0026, 4'b1100, 32'd0);
    a_ready = 1'b0;
    addr_phase(1'b1, 3'd2, 32'h0000_0020);
    step();
    addr_phase(1'b0, 3'd1, 32'h0000_0026);
    hwdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      chk("stall_a_valid", 32'(a_valid), 1);
      chk("stall_a_address", a_address, 32'h0000_0020);
      chk("stall_a_opcode", 32'(a_opcode), 0);
      chk("stall_hreadyout", 32'(hreadyout), 0);
      step();
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd0;
    step();
    d_valid = 1'b0;
    chk("b2b_wr_hreadyout", 32'(hreadyout), 1);
    chk("b2b_wr_hresp", 32'(hresp), 0);
    step();
    bus_idle();
    chk("b2b_rd_a_valid", 32'(a_valid), 1);
    chk("b2b_rd_a_opcode", 32'(a_opcode), 4);
    chk("b2b_rd_a_address", a_address, 32'h0000_0026);
    chk("b2b_rd_hreadyout", 32'(hreadyout), 0);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'hCAFE_F00D;
    step();
    d_valid = 1'b0;
    m_hrdata = 32'hCAFE_F00D;
    chk("b2b_rd_hrdata", hrdata, m_hrdata);
    chk("b2b_rd_done", 32'(hreadyout), 1);
    step();
`else
    // Posted write completes early; following read is held until the write's D beat
    push_a(1'b1, 3'd2, 32'h0000_0060, 4'hF, 32'h0000_0011);
    push_a(1'b0, 3'd2, 32'h0000_0064, 4'hF, 32'd0);
    addr_phase(1'b1, 3'd2, 32'h0000_0060);
    step();
    addr_phase(1'b0, 3'd2, 32'h0000_0064);
    hwdata = 32'h0000_0011;
    a_ready = 1'b1;
    step();
    chk("pw_resp_hreadyout", 32'(hreadyout), 1);
    chk("pw_resp_hresp", 32'(hresp), 0);
    step();
    bus_idle();
    chk("pw_hold_a_valid", 32'(a_valid), 0);
    chk("pw_hold_hreadyout", 32'(hreadyout), 0);
    step();
    chk("pw_hold2_a_valid", 32'(a_valid), 0);
    d_valid = 1'b1; d_opcode = 3'd0; d_denied = 1'b1;
    step();
    d_valid = 1'b0; d_denied = 1'b0;
    chk("pw_rd_a_valid", 32'(a_valid), 1);
    chk("pw_rd_hresp", 32'(hresp), 0);
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'h0000_0077;
    step();
    d_valid = 1'b0;
    m_hrdata = 32'h0000_0077;
    chk("pw_rd_hrdata", hrdata, m_hrdata);
    chk("pw_rd_resp_hresp", 32'(hresp), 0);
    step();
`endif

    // Reset while waiting for D abandons the transfer; the late beat is sunk
    push_a(1'b0, 3'd2, 32'h0000_0040, 4'hF, 32'd0);
    addr_phase(1'b0, 3'd2, 32'h0000_0040);
    step();
    bus_idle();
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    chk("rw_wait_d_ready", 32'(d_ready), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hrdata = 32'd0;
    chk("rw_hreadyout", 32'(hreadyout), 1);
    chk("rw_a_valid", 32'(a_valid), 0);
    chk("rw_hresp", 32'(hresp), 0);
    chk("rw_hrdata", hrdata, m_hrdata);
    step();
    chk("rw_sink_d_ready", 32'(d_ready), 1);
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'h0000_0055;
    step();
    d_valid = 1'b0;
    chk("rw_sunk_hrdata", hrdata, m_hrdata);
    chk("rw_sunk_hreadyout", 32'(hreadyout), 1);
    chk("rw_sunk_hresp", 32'(hresp), 0);
    chk("rw_sunk_a_valid", 32'(a_valid), 0);
    step();
    step();

    chk("a_pending", 32'(exp_a.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
